// File: rtl/micro_sim_pkg.sv
// micro_sim_pkg: shared state type, widths, pattern constants and output field positions
package micro_sim_pkg;
  typedef enum logic [1:0] {IDLE, FILL, PROC, DONE} state_t;
  localparam int MEM_DEPTH = 64;
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int PIX_W = 8;
  localparam int RES_W = PIX_W + 2;
  localparam int PAT_MUL = 5;
  localparam int PAT_OFF = 3;
  localparam int VALID_BIT = 31;
  localparam int IDX_LSB = 16;
  localparam int RES_LSB = 0;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  function automatic logic [PIX_W-1:0] pattern(input logic [ADDR_W-1:0] idx);
    return PIX_W'(PAT_MUL * int'(idx) + PAT_OFF);
  endfunction
endpackage

// File: rtl/micro_sim_conv121.sv
// micro_sim_conv121: pixel and result memories with the [1,2,1] three-tap convolution
module micro_sim_conv121
  import micro_sim_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              cmp_en,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [RES_W-1:0]  rd_data
);
  logic [PIX_W-1:0] pix_mem [MEM_DEPTH];
  logic [RES_W-1:0] res_mem [MEM_DEPTH];
  logic [PIX_W-1:0] left_pix, mid_pix, right_pix;
  logic [RES_W-1:0] sum;
  // neighbours beyond either end of the line contribute zero
  always_comb begin
    left_pix = cmp_addr == '0 ? '0 : pix_mem[cmp_addr - 1'b1];
    mid_pix = pix_mem[cmp_addr];
    right_pix = cmp_addr == LAST ? '0 : pix_mem[cmp_addr + 1'b1];
    sum = RES_W'(left_pix) + RES_W'({mid_pix, 1'b0}) + RES_W'(right_pix);
  end
  // pattern fill and convolution write-back; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) pix_mem[wr_addr] <= wr_data;
    if (cmp_en) res_mem[cmp_addr] <= sum;
  end
  assign rd_data = res_mem[rd_addr];
endmodule

// File: rtl/micro_sim.sv
// micro_sim: GPIO-driven stand-in MCU that fills a pattern, convolves it and steps results out
module micro_sim
  import micro_sim_pkg::*;
#(
  parameter int GPIO_D = 32
) (
  input  logic              CLK100MHZ,
  input  logic [GPIO_D-1:0] gpio_o_data_tri_o,
  output logic [GPIO_D-1:0] gpio_i_data_tri_i,
  output logic              o_led
);
  logic clk, rst, start_ev, step_ev, unused_bits;
  logic [1:0] prev;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr, rd_ptr;
  logic [RES_W-1:0] rd_data;
  logic [GPIO_D-1:0] step_word;
  assign clk = CLK100MHZ;
  assign rst = gpio_o_data_tri_o[0];
  assign unused_bits = ^gpio_o_data_tri_o[GPIO_D-1:3];
  assign start_ev = gpio_o_data_tri_o[1] & ~prev[0];
  assign step_ev = gpio_o_data_tri_o[2] & ~prev[1];
  assign o_led = state == DONE;
  // sequencing: a start kicks off fill then convolve; DONE waits for steps or a restart
  always_comb begin
    state_nxt = (state == IDLE && start_ev) ? FILL :
                (state == FILL && ptr == LAST) ? PROC :
                (state == PROC && ptr == LAST) ? DONE :
                (state == DONE && start_ev) ? FILL : state;
  end
  // status word: valid flag, result index and result value, all other bits zero
  always_comb begin
    step_word = '0;
    step_word[VALID_BIT] = 1'b1;
    step_word[IDX_LSB +: ADDR_W] = rd_ptr;
    step_word[RES_LSB +: RES_W] = rd_data;
  end
  // state, pointers, edge-detect history and the registered host word; start beats step in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      rd_ptr <= '0;
      prev <= '0;
      gpio_i_data_tri_i <= '0;
    end else begin
      state <= state_nxt;
      prev <= gpio_o_data_tri_o[2:1];
      ptr <= (state inside {FILL, PROC} && ptr != LAST) ? ptr + 1'b1 : '0;
      rd_ptr <= (state != DONE || start_ev) ? '0 :
                step_ev ? (rd_ptr == LAST ? '0 : rd_ptr + 1'b1) : rd_ptr;
      gpio_i_data_tri_i <= (state == DONE && start_ev) ? '0 :
                           (state == DONE && step_ev) ? step_word : gpio_i_data_tri_i;
    end
  end
  micro_sim_conv121 u_conv (
    .clk      (clk),
    .wr_en    (state == FILL),
    .wr_addr  (ptr),
    .wr_data  (pattern(ptr)),
    .cmp_en   (state == PROC),
    .cmp_addr (ptr),
    .rd_addr  (rd_ptr),
    .rd_data  (rd_data)
  );
endmodule

// File: tb/tb_micro_sim.sv
// tb_micro_sim: table and scoreboard driven check of micro_sim
module tb_micro_sim;
  logic clk = 1'b0;
  logic [31:0] cmd = '0;
  logic [31:0] dout;
  logic led;
  int checks = 0;
  int failures = 0;
  int sb_idx = 0;
  int t1, t2, t3;
  logic [31:0] exp_q[$];
  typedef struct {int len; logic [31:0] exp;} vec_t;
  vec_t tbl[4];

  micro_sim dut (
    .CLK100MHZ         (clk),
    .gpio_o_data_tri_o (cmd),
    .gpio_i_data_tri_i (dout),
    .o_led             (led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pix(input int j);
    return (j < 0 || j > 63) ? 0 : (5 * j + 3) % 256;
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    int r;
    r = pix(i - 1) + 2 * pix(i) + pix(i + 1);
    return {1'b1, 9'b0, 6'(i), 6'b0, 10'(r)};
  endfunction

  task automatic do_step(input int len, input logic [31:0] exp);
    exp_q.push_back(exp);
    sb_idx = (sb_idx + 1) % 64;
    cmd[2] = 1'b1;
    tick(len);
    cmd[2] = 1'b0;
    tick(3);
    check($sformatf("step_idx%0d", (sb_idx + 63) % 64), dout, exp_q.pop_front());
  endtask

  task automatic do_reset();
    cmd = 32'h1;
    tick(2);
    cmd = '0;
    tick(1);
    sb_idx = 0;
  endtask

  task automatic run_start(input bit inject, output int cyc);
    cyc = 0;
    cmd = 32'h2;
    tick(1);
    cyc = 1;
    cmd = '0;
    while (!led && cyc < 400) begin
      if (inject && cyc == 10) cmd = 32'h6;
      if (inject && cyc == 12) cmd = 32'h0;
      if (inject && cyc == 70) cmd = 32'h4;
      if (inject && cyc == 72) cmd = 32'h0;
      tick(1);
      cyc++;
    end
    sb_idx = 0;
  endtask

  task automatic run_table();
    for (int k = 0; k < 4; k++) do_step(tbl[k].len, tbl[k].exp);
  endtask

  initial begin
    tbl[0] = '{1, 32'h8000000E};
    tbl[1] = '{1, 32'h80010020};
    tbl[2] = '{3, 32'h80020034};
    tbl[3] = '{1, 32'h80030048};
    tick(2);
    do_reset();
    check("reset_out", dout, 32'h0);
    check("reset_led", {31'b0, led}, 32'h0);
    cmd = 32'h4;
    tick(2);
    cmd = '0;
    tick(3);
    check("idle_step_ignored", dout, 32'h0);
    run_start(1'b0, t1);
    checks++;
    if (t1 < 126 || t1 > 134) begin
      failures++;
      $display("FAIL led_latency: got %0d cycles expected 126..134", t1);
    end
    tick(5);
    check("led_holds", {31'b0, led}, 32'h1);
    check("done_out_before_step", dout, 32'h0);
    run_table();
    for (int i = 4; i < 64; i++) do_step(1, exp_word(i));
    check("last_word", dout, 32'h803F00B5);
    do_step(1, 32'h8000000E);
    do_reset();
    check("reset_after_done_out", dout, 32'h0);
    run_start(1'b1, t2);
    check("restart_in_fill_ignored_latency", t2, t1);
    check("steps_during_busy_ignored", dout, 32'h0);
    do_reset();
    cmd = 32'h2;
    tick(1);
    cmd = '0;
    tick(90);
    cmd = 32'h1;
    tick(1);
    cmd = '0;
    tick(1);
    check("mid_proc_reset_out", dout, 32'h0);
    check("mid_proc_reset_led", {31'b0, led}, 32'h0);
    tick(140);
    check("stays_idle_after_reset", {31'b0, led}, 32'h0);
    run_start(1'b0, t3);
    check("rerun_latency", t3, t1);
    run_table();
    do_step(10, exp_word(4));
    do_step(1, exp_word(5));
    cmd = 32'h6;
    tick(1);
    cmd = '0;
    tick(2);
    check("start_in_done_led", {31'b0, led}, 32'h0);
    check("start_in_done_out", dout, 32'h0);
    t3 = 0;
    while (!led && t3 < 300) begin
      tick(1);
      t3++;
    end
    check("restart_done", {31'b0, led}, 32'h1);
    sb_idx = 0;
    do_step(1, 32'h8000000E);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
